// File: rtl/adder_3_bits.sv
// adder_3_bits
// ------------
// Registered 3-bit ripple-carry adder built from three chained full-adder
// cells. Operand bits and a carry-in are summed combinationally through a
// pure ripple chain (no lookahead, no carry-select). The 4-bit result is
// captured into output registers on the rising clock edge when in_vld is
// high, so results appear exactly one cycle after the operands are
// presented. Carry-out can feed the carry-in of the next slice of a wider
// ripple adder.
//
// Optional feature macro: ADDER_3_BITS_OVF_EN
//    When defined, a registered signed two's-complement overflow flag (ovf)
//    is added. It is captured with the sum, reset with it and held with it.
//    When undefined, the ovf port and all of its logic are absent.
//
// Ports:
//    clk      in   clock, all state updates on the rising edge
//    rst      in   synchronous active-high reset, priority over in_vld
//    a0..a2   in   operand A bits, a0 = LSB
//    b0..b2   in   operand B bits, b0 = LSB
//    cin      in   carry into bit 0
//    in_vld   in   operands valid this cycle
//    s0..s2   out  registered sum bits, s0 = LSB
//    cout     out  registered carry out of bit 2
//    out_vld  out  registered outputs hold a new result this cycle
//    ovf      out  registered signed overflow (only with the macro)

module adder_3_bits (
   input  logic clk,
   input  logic rst,
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic b0,
   input  logic b1,
   input  logic b2,
   input  logic cin,
   input  logic in_vld,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic cout,
`ifdef ADDER_3_BITS_OVF_EN
   output logic ovf,
`endif
   output logic out_vld
);

   logic [2:0] opA;
   logic [2:0] opB;
   logic [3:0] carry;
   logic [2:0] sumComb;

   logic [2:0] sum_d;
   logic [2:0] sum_q;
   logic       cout_d;
   logic       cout_q;
   logic       out_vld_d;
   logic       out_vld_q;
`ifdef ADDER_3_BITS_OVF_EN
   logic       ovf_d;
   logic       ovf_q;
`endif

   assign opA = {a2, a1, a0};
   assign opB = {b2, b1, b0};

   // Ripple carry chain: each full-adder cell produces its sum bit and
   // hands its carry to the next cell. carry[0] is the external carry-in
   // and carry[3] is the carry out of the top bit. Written bit by bit so
   // the structure stays a plain ripple rather than a tool-chosen adder.
   always_comb begin
      carry   = '0;
      sumComb = '0;
      carry[0] = cin;
      for (int i = 0; i < 3; i++) begin
         sumComb[i]   = opA[i] ^ opB[i] ^ carry[i];
         carry[i + 1] = (opA[i] & opB[i]) | (carry[i] & (opA[i] ^ opB[i]));
      end
   end

   // Next-state selection for the output registers. Defaults keep the
   // current result so that an idle cycle holds the last sum; out_vld only
   // marks the single cycle right after a capture, so it defaults low.
   always_comb begin
      sum_d     = sum_q;
      cout_d    = cout_q;
      out_vld_d = 1'b0;
`ifdef ADDER_3_BITS_OVF_EN
      ovf_d     = ovf_q;
`endif
      if (in_vld) begin
         sum_d     = sumComb;
         cout_d    = carry[3];
         out_vld_d = 1'b1;
`ifdef ADDER_3_BITS_OVF_EN
         // Signed overflow: the carry into the sign bit disagrees with the
         // carry out of it.
         ovf_d     = carry[2] ^ carry[3];
`endif
      end
   end

   // Output registers with synchronous reset. Reset wins over in_vld, so a
   // reset edge always leaves a clean zero result with out_vld low.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q     <= '0;
         cout_q    <= 1'b0;
         out_vld_q <= 1'b0;
`ifdef ADDER_3_BITS_OVF_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         out_vld_q <= out_vld_d;
`ifdef ADDER_3_BITS_OVF_EN
         ovf_q     <= ovf_d;
`endif
      end
   end

   // Outputs come straight from registers, so there is no combinational
   // path from any input to any output.
   assign s0      = sum_q[0];
   assign s1      = sum_q[1];
   assign s2      = sum_q[2];
   assign cout    = cout_q;
   assign out_vld = out_vld_q;
`ifdef ADDER_3_BITS_OVF_EN
   assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_adder_3_bits.sv
// tb_adder_3_bits
// ---------------
// Directed testbench for adder_3_bits. Inputs are driven on the falling
// edge, outputs are sampled 1 time unit after the rising edge. Expected
// values are hand-computed constants or come from a plain integer model of
// A + B + cin (and of the signed range check for ovf).

module tb_adder_3_bits;

   logic clk;
   logic rst;
   logic a0, a1, a2;
   logic b0, b1, b2;
   logic cin;
   logic in_vld;
   logic s0, s1, s2;
   logic cout;
   logic out_vld;
`ifdef ADDER_3_BITS_OVF_EN
   logic ovf;
`endif

   int compared;
   int mismatched;

   adder_3_bits dut (
      .clk     (clk),
      .rst     (rst),
      .a0      (a0),
      .a1      (a1),
      .a2      (a2),
      .b0      (b0),
      .b1      (b1),
      .b2      (b2),
      .cin     (cin),
      .in_vld  (in_vld),
      .s0      (s0),
      .s1      (s1),
      .s2      (s2),
      .cout    (cout),
`ifdef ADDER_3_BITS_OVF_EN
      .ovf     (ovf),
`endif
      .out_vld (out_vld)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one set of operands and control inputs.
   task automatic applyStimulus(input logic [2:0] aV, input logic [2:0] bV,
                                input logic cinV, input logic vldV);
      a0     = aV[0];
      a1     = aV[1];
      a2     = aV[2];
      b0     = bV[0];
      b1     = bV[1];
      b2     = bV[2];
      cin    = cinV;
      in_vld = vldV;
   endtask

   // Advance to just after the next rising edge, where outputs are stable.
   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Reset with in_vld high and nonzero operands: reset must win.
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(3'b111, 3'b101, 1'b1, 1'b1);
      stepEdge();
      compared++;
      if ({cout, s2, s1, s0} !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_sum got %b expected 0000", {cout, s2, s1, s0});
      end
      compared++;
      if (out_vld !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_out_vld got %b expected 0", out_vld);
      end
`ifdef ADDER_3_BITS_OVF_EN
      compared++;
      if (ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_ovf got %b expected 0", ovf);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
   endtask

   // The four directed cases, applied back to back with hand-computed results.
   task automatic test_directed_cases();
      logic [2:0] caseA   [4];
      logic [2:0] caseB   [4];
      logic       caseCin [4];
      logic [3:0] expRes  [4];
      logic       expOvf  [4];
      caseA[0] = 3'b001; caseB[0] = 3'b001; caseCin[0] = 1'b1; expRes[0] = 4'b0011; expOvf[0] = 1'b0;
      caseA[1] = 3'b011; caseB[1] = 3'b010; caseCin[1] = 1'b1; expRes[1] = 4'b0110; expOvf[1] = 1'b1;
      caseA[2] = 3'b011; caseB[2] = 3'b100; caseCin[2] = 1'b0; expRes[2] = 4'b0111; expOvf[2] = 1'b0;
      caseA[3] = 3'b111; caseB[3] = 3'b001; caseCin[3] = 1'b1; expRes[3] = 4'b1001; expOvf[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         applyStimulus(caseA[i], caseB[i], caseCin[i], 1'b1);
         stepEdge();
         compared++;
         if ({cout, s2, s1, s0} !== expRes[i]) begin
            mismatched++;
            $display("[TB] FAIL case%0d_result got %b expected %b", i + 1,
                     {cout, s2, s1, s0}, expRes[i]);
         end
         compared++;
         if (out_vld !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL case%0d_out_vld got %b expected 1", i + 1, out_vld);
         end
`ifdef ADDER_3_BITS_OVF_EN
         compared++;
         if (ovf !== expOvf[i]) begin
            mismatched++;
            $display("[TB] FAIL case%0d_ovf got %b expected %b", i + 1, ovf, expOvf[i]);
         end
`else
         if (expOvf[i] === 1'bx) $display("[TB] unreachable");
`endif
      end
   endtask

   // Drop in_vld after case 4 and wiggle operands: result must hold at
   // 1001 (cout=1, s=001) and out_vld must go low.
   task automatic test_hold();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         applyStimulus(3'b010, 3'b110, 1'b0, 1'b0);
         #2;
         applyStimulus(3'b101, 3'b011, 1'b1, 1'b0);
         stepEdge();
         compared++;
         if ({cout, s2, s1, s0} !== 4'b1001) begin
            mismatched++;
            $display("[TB] FAIL hold%0d_result got %b expected 1001", i, {cout, s2, s1, s0});
         end
         compared++;
         if (out_vld !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hold%0d_out_vld got %b expected 0", i, out_vld);
         end
`ifdef ADDER_3_BITS_OVF_EN
         compared++;
         if (ovf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hold%0d_ovf got %b expected 0", i, ovf);
         end
`endif
      end
   endtask

   // Sweep all 128 {A, B, cin} combinations with in_vld held high, one per
   // cycle, checking each result one edge after it is presented.
   task automatic test_back_to_back();
      logic [2:0] aV;
      logic [2:0] bV;
      logic       cV;
      logic [3:0] expRes;
      logic       expOvf;
      int         sa;
      int         sb;
      int         total;
      for (int v = 0; v < 128; v++) begin
         aV = v[6:4];
         bV = v[3:1];
         cV = v[0];
         expRes = 4'(int'(aV) + int'(bV) + int'(cV));
         sa = (aV >= 3'd4) ? int'(aV) - 8 : int'(aV);
         sb = (bV >= 3'd4) ? int'(bV) - 8 : int'(bV);
         total = sa + sb + int'(cV);
         expOvf = (total > 3) || (total < -4);
         @(negedge clk);
         applyStimulus(aV, bV, cV, 1'b1);
         stepEdge();
         compared++;
         if ({cout, s2, s1, s0} !== expRes || out_vld !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sweep A=%b B=%b cin=%b got res=%b vld=%b expected res=%b vld=1",
                     aV, bV, cV, {cout, s2, s1, s0}, out_vld, expRes);
         end
`ifdef ADDER_3_BITS_OVF_EN
         compared++;
         if (ovf !== expOvf) begin
            mismatched++;
            $display("[TB] FAIL sweep_ovf A=%b B=%b cin=%b got %b expected %b",
                     aV, bV, cV, ovf, expOvf);
         end
`else
         if (expOvf === 1'bx) $display("[TB] unreachable");
`endif
      end
      @(negedge clk);
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
      stepEdge();
      compared++;
      if (out_vld !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL sweep_end_out_vld got %b expected 0", out_vld);
      end
   endtask

   // Test sequence.
   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b0;
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
      test_reset();
      test_directed_cases();
      test_hold();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/adder_3_bits.md
# adder_3_bits

Registered 3-bit ripple-carry adder (CPA) built from three chained full-adder cells. It sums two 3-bit operands given as individual bits plus a carry-in and presents the 3-bit sum and carry-out from output registers one clock later. It is a leaf arithmetic block, used standalone in coursework datapaths or as the slice of a wider ripple adder. Carry-out can feed the next slice's carry-in.

## Interface

Parameters: none.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- a0, a1, a2  input  1 each  operand A bits, a0 = LSB.
- b0, b1, b2  input  1 each  operand B bits, b0 = LSB.
- cin  input  1  carry into bit 0.
- in_vld  input  1  operands valid this cycle.
- s0, s1, s2  output  1 each  registered sum bits, s0 = LSB.
- cout  output  1  registered carry out of bit 2.
- out_vld  output  1  registered outputs hold a new result.
- ovf  output  1  registered signed two's-complement overflow; present only with ADDER_3_BITS_OVF_EN.

## Operation

- Per bit i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = cin; cout = c_3.
- {cout, s2, s1, s0} = {a2,a1,a0} + {b2,b1,b0} + cin, unsigned, range 0..15; no truncation beyond the 4-bit result.
- Carry chain is pure ripple: no lookahead, no carry-select.
- Capture: on a rising edge with in_vld = 1, the sum and cout registers load the combinational result and out_vld is set to 1.
- Hold: on a rising edge with in_vld = 0, the sum and cout registers keep their previous value and out_vld is cleared to 0.
- Inputs are sampled only at rising edges. Changes between edges have no effect on the outputs.

## Timing

- Reset: a rising edge with rst = 1 forces s0, s1, s2, cout, out_vld (and ovf) to 0.
- Reset has priority over in_vld when both are 1.
- The first capture can occur on the edge after rst is deasserted.
- Latency: exactly 1 cycle. Operands presented with in_vld = 1 before edge N appear on the outputs after edge N, with out_vld = 1 for that cycle.
- Throughput: one addition per cycle. Back-to-back in_vld produces back-to-back results.
- Combinational path: the full 3-stage carry ripple from inputs to the register D pins must meet one clk period.
- No combinational path from any input to any output.

## Configuration

- ADDER_3_BITS_OVF_EN defined:
  - Output ovf is present.
  - It is captured with the sum: ovf = c_2 ^ c_3, i.e. the signed operands in the range −4..3 produced a sum outside −4..3.
  - It is reset to 0 and held alongside the sum.
- ADDER_3_BITS_OVF_EN undefined:
  - Port ovf is absent, and so is its logic.
  - All other behaviour is identical.

## Test plan

- Reset check: assert rst with in_vld = 1 and nonzero operands for 1 edge -> s2..s0 = 000, cout = 0, out_vld = 0, ovf = 0.
- Case 1: A = 001, B = 001, cin = 1, in_vld = 1 -> after 1 edge: s = 011, cout = 0, out_vld = 1, ovf = 0.
- Case 2: A = 011, B = 010, cin = 1 -> s = 110, cout = 0, ovf = 1.
- Case 3: A = 011, B = 100, cin = 0 -> s = 111, cout = 0, ovf = 0.
- Case 4: A = 111, B = 001, cin = 1 -> s = 001, cout = 1, ovf = 0.
- Hold and exhaustive check:
  - Drop in_vld after case 4 -> outputs stay s = 001, cout = 1, with out_vld = 0.
  - Then sweep all 128 {A, B, cin} combinations back-to-back -> every result equals A + B + cin with 1-cycle latency.
